// File: rtl/sprite_reg_writer.sv
// Bus master for the sprite display controller: uploads both sprite bitmaps after reset,
// then writes fresh spaceship/planet positions on every vertical-sync interrupt.
module sprite_reg_writer #(
    parameter int unsigned SPRITE_SIZE = 16,
    parameter int unsigned SCREEN_W    = 640,
    parameter int unsigned SCREEN_H    = 480,
    parameter int unsigned SHIP_STEP   = 2,
    parameter int unsigned PLANET_STEP = 1,
    parameter int unsigned SHIP_X0     = 32,
    parameter int unsigned SHIP_Y0     = 232,
    parameter int unsigned PLANET_X0   = 624,
    parameter int unsigned PLANET_Y0   = 100
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        IRQ_Vsync,
    input  logic        move_up,
    input  logic        move_down,
    input  logic        move_left,
    input  logic        move_right,
    output logic [4:0]  bmp_addr,
    input  logic [15:0] bmp_data,
    output logic        wren,
    output logic [5:0]  addr,
    output logic [15:0] ldr,
    output logic        busy
);

    localparam logic [9:0] XMax  = 10'(SCREEN_W - SPRITE_SIZE);
    localparam logic [9:0] YMax  = 10'(SCREEN_H - SPRITE_SIZE);
    localparam logic [9:0] SStep = 10'(SHIP_STEP);
    localparam logic [9:0] PStep = 10'(PLANET_STEP);

    typedef enum logic [2:0] {
        StLoadAddr,
        StLoadSetup,
        StLoadStrobe,
        StIdle,
        StUpdate,
        StWrSetup,
        StWrStrobe
    } state_e;

    state_e      state_q, state_d;
    logic [4:0]  k_q, k_d;
    logic [1:0]  w_q, w_d;
    logic        pending_q, pending_d;
    logic [9:0]  ship_x_q, ship_x_d;
    logic [9:0]  ship_y_q, ship_y_d;
    logic [9:0]  planet_x_q, planet_x_d;
    logic [2:0]  sync_q;
    logic        rise_q;
    logic        wren_q;
    logic [5:0]  addr_q, addr_c;
    logic [15:0] ldr_q, ldr_c;
    logic [9:0]  wr_pos;

    // One ship axis: opposing or absent inputs hold, otherwise step and clamp to the screen.
    function automatic logic [9:0] step_axis(input logic [9:0] pos, input logic dec,
                                             input logic inc, input logic [9:0] max);
        logic [10:0] sum;
        sum = {1'b0, pos} + {1'b0, SStep};
        if (dec && !inc) begin
            return (pos >= SStep) ? pos - SStep : 10'd0;
        end else if (inc && !dec) begin
            return (sum > {1'b0, max}) ? max : sum[9:0];
        end
        return pos;
    endfunction

    always_comb begin
        unique case (w_q)
            2'd0: wr_pos = ship_x_q;
            2'd1: wr_pos = ship_y_q;
            2'd2: wr_pos = planet_x_q;
            2'd3: wr_pos = 10'(PLANET_Y0);
        endcase
    end

    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        w_d        = w_q;
        pending_d  = pending_q;
        ship_x_d   = ship_x_q;
        ship_y_d   = ship_y_q;
        planet_x_d = planet_x_q;
        addr_c     = addr_q;
        ldr_c      = ldr_q;

        if (rise_q && state_q != StIdle) begin
            pending_d = 1'b1;
        end

        unique case (state_q)
            StLoadAddr: state_d = StLoadSetup;
            StLoadSetup: begin
                addr_c  = {1'b0, k_q};
                ldr_c   = bmp_data;
                state_d = StLoadStrobe;
            end
            StLoadStrobe: begin
                if (k_q == 5'd31) begin
                    state_d = StIdle;
                end else begin
                    k_d     = k_q + 5'd1;
                    state_d = StLoadAddr;
                end
            end
            StIdle: begin
                if (rise_q || pending_q) begin
                    pending_d = 1'b0;
                    state_d   = StUpdate;
                end
            end
            StUpdate: begin
                ship_x_d   = step_axis(ship_x_q, move_left, move_right, XMax);
                ship_y_d   = step_axis(ship_y_q, move_up, move_down, YMax);
                planet_x_d = (planet_x_q >= PStep) ? planet_x_q - PStep : XMax;
                w_d        = 2'd0;
                state_d    = StWrSetup;
            end
            StWrSetup: begin
                addr_c  = {4'b1000, w_q};
                ldr_c   = {6'b0, wr_pos};
                state_d = StWrStrobe;
            end
            StWrStrobe: begin
                if (w_q == 2'd3) begin
                    state_d = StIdle;
                end else begin
                    w_d     = w_q + 2'd1;
                    state_d = StWrSetup;
                end
            end
            default: state_d = StLoadAddr;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StLoadAddr;
            k_q        <= 5'd0;
            w_q        <= 2'd0;
            pending_q  <= 1'b0;
            ship_x_q   <= 10'(SHIP_X0);
            ship_y_q   <= 10'(SHIP_Y0);
            planet_x_q <= 10'(PLANET_X0);
            sync_q     <= 3'b000;
            rise_q     <= 1'b0;
            wren_q     <= 1'b0;
            addr_q     <= 6'd0;
            ldr_q      <= 16'd0;
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            w_q        <= w_d;
            pending_q  <= pending_d;
            ship_x_q   <= ship_x_d;
            ship_y_q   <= ship_y_d;
            planet_x_q <= planet_x_d;
            // Two synchronizer stages plus a delay stage; edge flag is registered once more.
            sync_q     <= {sync_q[1:0], IRQ_Vsync};
            rise_q     <= sync_q[1] & ~sync_q[2];
            // Strobe comes straight from a flop so the sink never sees a decode glitch.
            wren_q     <= (state_d == StLoadStrobe) || (state_d == StWrStrobe);
            addr_q     <= addr_c;
            ldr_q      <= ldr_c;
        end
    end

    assign bmp_addr = k_q;
    assign wren     = wren_q;
    assign addr     = addr_c;
    assign ldr      = ldr_c;
    assign busy     = (state_q != StIdle);

endmodule

// File: tb/tb_sprite_reg_writer.sv
// Scoreboard bench for sprite_reg_writer: a frame-level position model queues expected
// register writes, a monitor pops and compares one entry per wren pulse.
module tb_sprite_reg_writer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        irq = 1'b0;
    logic        move_up = 1'b0, move_down = 1'b0, move_left = 1'b0, move_right = 1'b0;
    logic [4:0]  bmp_addr;
    logic [15:0] bmp_data;
    logic        wren;
    logic [5:0]  addr;
    logic [15:0] ldr;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int exp_addr[$];
    int exp_data[$];
    int sx, sy, px;
    int ea, ed;
    logic wren_prev = 1'b0;

    sprite_reg_writer dut (
        .clk       (clk),
        .reset     (reset),
        .IRQ_Vsync (irq),
        .move_up   (move_up),
        .move_down (move_down),
        .move_left (move_left),
        .move_right(move_right),
        .bmp_addr  (bmp_addr),
        .bmp_data  (bmp_data),
        .wren      (wren),
        .addr      (addr),
        .ldr       (ldr),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Synchronous bitmap ROM: row r holds A500 + r.
    always @(posedge clk) bmp_data <= 16'hA500 + {11'b0, bmp_addr};

    always @(negedge clk) begin
        if (wren === 1'b1) begin
            checks++;
            if (wren_prev === 1'b1) begin
                errors++;
                $display("FAIL wren_back_to_back t=%0t: wren high in consecutive cycles, required 0",
                         $time);
            end else if (exp_addr.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write t=%0t: addr=%0h ldr=%0h, required no write",
                         $time, addr, ldr);
            end else begin
                ea = exp_addr.pop_front();
                ed = exp_data.pop_front();
                checks++;
                if (addr !== 6'(ea) || ldr !== 16'(ed)) begin
                    errors++;
                    $display("FAIL write t=%0t: got addr=%0h ldr=%0h, required addr=%0h ldr=%0h",
                             $time, addr, ldr, ea, ed);
                end
            end
        end
        wren_prev = wren;
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        sx = 32;
        sy = 232;
        px = 624;
    endtask

    task automatic push_loads();
        for (int r = 0; r < 32; r++) begin
            exp_addr.push_back(r);
            exp_data.push_back(16'hA500 + r);
        end
    endtask

    // mv = {left, right, up, down}; applies the moves and queues the first nwr writes.
    task automatic push_frame(input logic [3:0] mv, input int nwr);
        int vals[4];
        move_left  = mv[3];
        move_right = mv[2];
        move_up    = mv[1];
        move_down  = mv[0];
        if (mv[3] && !mv[2]) sx = (sx >= 2) ? sx - 2 : 0;
        else if (mv[2] && !mv[3]) sx = (sx + 2 > 640 - 16) ? 640 - 16 : sx + 2;
        if (mv[1] && !mv[0]) sy = (sy >= 2) ? sy - 2 : 0;
        else if (mv[0] && !mv[1]) sy = (sy + 2 > 480 - 16) ? 480 - 16 : sy + 2;
        px = (px >= 1) ? px - 1 : 640 - 16;
        vals = '{sx, sy, px, 100};
        for (int i = 0; i < nwr; i++) begin
            exp_addr.push_back(32 + i);
            exp_data.push_back(vals[i]);
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_addr.size() != 0 || busy !== 1'b0) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", (n >= 3000) ? 1 : 0, 0);
        repeat (3) @(negedge clk);
    endtask

    task automatic frame(input logic [3:0] mv);
        push_frame(mv, 4);
        irq = 1'b1;
        @(negedge clk);
        irq = 1'b0;
        drain();
    endtask

    initial begin
        int n;
        logic [3:0] mv;

        model_reset();
        repeat (3) @(negedge clk);
        check("reset_wren", int'(wren), 0);
        check("reset_addr", int'(addr), 0);
        check("reset_ldr", int'(ldr), 0);
        check("reset_busy", int'(busy), 1);
        check("reset_bmp_addr", int'(bmp_addr), 0);

        push_loads();
        reset = 1'b0;
        n = 0;
        while (busy !== 1'b0 && n < 200) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        check("load_cycles", n, 96);
        check("load_writes_left", exp_addr.size(), 0);
        repeat (3) @(negedge clk);

        // First frame, no moves: measure strobe latency from the sampling edge.
        push_frame(4'b0000, 4);
        irq = 1'b1;
        @(negedge clk);
        irq = 1'b0;
        n = 0;
        while (wren !== 1'b1 && n < 30) begin
            @(negedge clk);
            n++;
        end
        check("first_wren_latency", n, 5);
        drain();

        frame(4'b1100);
        frame(4'b0011);

        // Reset while the planet_x write is being set up, plus a rise during the reload.
        push_frame(4'b0101, 2);
        irq = 1'b1;
        @(negedge clk);
        irq = 1'b0;
        repeat (8) @(negedge clk);
        check("pre_reset_writes_left", exp_addr.size(), 0);
        reset = 1'b1;
        @(negedge clk);
        check("mid_reset_wren", int'(wren), 0);
        check("mid_reset_busy", int'(busy), 1);
        check("mid_reset_bmp_addr", int'(bmp_addr), 0);
        reset = 1'b0;
        model_reset();
        push_loads();
        repeat (10) @(negedge clk);
        push_frame(4'b0101, 4);
        irq = 1'b1;
        @(negedge clk);
        irq = 1'b0;
        drain();

        // Three rises: first starts an update, the next two collapse into one extra update.
        push_frame(4'b1010, 4);
        push_frame(4'b1010, 4);
        for (int j = 0; j < 3; j++) begin
            irq = 1'b1;
            @(negedge clk);
            irq = 1'b0;
            repeat (2) @(negedge clk);
        end
        drain();

        // Level held high yields exactly one update.
        push_frame(4'b0100, 4);
        irq = 1'b1;
        repeat (40) @(negedge clk);
        drain();
        irq = 1'b0;
        repeat (4) @(negedge clk);

        // Drive ship into both clamps, then random moves long enough for the planet to wrap.
        for (int i = 0; i < 640; i++) begin
            if (i < 24) mv = 4'b1010;
            else if (i < 360) mv = 4'b0101;
            else mv = 4'($urandom_range(0, 15));
            frame(mv);
        end

        check("final_queue_empty", exp_addr.size(), 0);
        check("final_busy", int'(busy), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sprite_reg_writer.md
# sprite_reg_writer

Bus-master front end for the VGA sprite display controller: drives that controller's register-write port (`wren`/`addr`/`ldr`) instead of the CPU. After reset it uploads both 16×16 sprite bitmaps from an external bitmap ROM. On every rising edge of `IRQ_Vsync` it computes the new frame's positions and writes them:

- the spaceship moves according to the direction inputs;
- the planet drifts left and wraps.

## Interface

Parameters:

- `SPRITE_SIZE`, 16, sprite edge in pixels
- `SCREEN_W`, 640, visible width
- `SCREEN_H`, 480, visible height
- `SHIP_STEP`, 2, spaceship pixels per frame per axis
- `PLANET_STEP`, 1, planet leftward pixels per frame
- `SHIP_X0`, 32, spaceship reset X
- `SHIP_Y0`, 232, spaceship reset Y
- `PLANET_X0`, 624, planet reset X
- `PLANET_Y0`, 100, planet Y (constant)

Ports (one clock; reset is synchronous and active-high):

- `clk`  in  1  system clock (same clock as the display controller)
- `reset`  in  1  synchronous, active-high reset
- `IRQ_Vsync`  in  1  frame interrupt from the display controller; treated as asynchronous
- `move_up`, `move_down`, `move_left`, `move_right`  in  1 each  direction levels
- `bmp_addr`  out  5  bitmap ROM address; rows 0-15 are the spaceship, rows 16-31 are the planet
- `bmp_data`  in  16  bitmap ROM data; valid one cycle after `bmp_addr`
- `wren`  out  1  register write strobe; the sink latches on its rising edge
- `addr`  out  6  register address
- `ldr`  out  16  register write data
- `busy`  out  1  high in every state except IDLE

## Operation

States: LOAD_ADDR, LOAD_SETUP, LOAD_STROBE, IDLE, UPDATE, WR_SETUP, WR_STROBE.

Reset:
- Every output is 0 except `busy`=1.
- Row counter k=0, write index w=0, pending=0.
- Positions are set to ship=(`SHIP_X0`,`SHIP_Y0`) and planet=(`PLANET_X0`,`PLANET_Y0`).
- Next state is LOAD_ADDR.

Bitmap load (k = 0..31):
- LOAD_ADDR: `bmp_addr`=k.
- LOAD_SETUP: `ldr`=`bmp_data`, `addr`={1'b0,k}, `wren`=0.
- LOAD_STROBE: `wren`=1 with `addr`/`ldr` held.
- If k=31, go to IDLE; otherwise k++ and go to LOAD_ADDR.
- Total 96 cycles, 32 writes to addresses 0x00-0x1F.

Frame update:
- `IRQ_Vsync` passes through a 2-flop synchronizer followed by a third delay flop. A rise is detected when s2=1 and s3=0.
- A rise detected in any state other than IDLE sets `pending`.
- IDLE goes to UPDATE on a rise or when `pending`=1. Entering UPDATE clears `pending`.
- UPDATE samples the move inputs and computes positions in 10-bit unsigned arithmetic:
  - X: left only → `ship_x` = (`ship_x` ≥ `SHIP_STEP`) ? `ship_x`−`SHIP_STEP` : 0.
  - X: right only → min(`ship_x`+`SHIP_STEP`, `SCREEN_W`−`SPRITE_SIZE`).
  - X: both or neither → hold.
  - Y follows the same rule using up (minus), down (plus) and `SCREEN_H`−`SPRITE_SIZE`.
  - `planet_x` = (`planet_x` ≥ `PLANET_STEP`) ? `planet_x`−`PLANET_STEP` : `SCREEN_W`−`SPRITE_SIZE`.
- Writes, for w = 0..3:
  - w=0: `addr` 0x20, `ship_x`
  - w=1: `addr` 0x21, `ship_y`
  - w=2: `addr` 0x22, `planet_x`
  - w=3: `addr` 0x23, `planet_y`
- Each write is WR_SETUP (`addr`/`ldr`={6'b0,pos}, `wren`=0) followed by WR_STROBE (`wren`=1).
- After w=3, go to IDLE.

General rules:
- `wren` is never high in two consecutive cycles.
- `addr`/`ldr` change only in SETUP states.
- Outside STROBE states `wren`=0.
- In IDLE, `addr`/`ldr` hold their last values.

## Timing

- Edge 0 is the first `clk` edge that samples `IRQ_Vsync`=1 while in IDLE. At edge 2 the rise is detected; FSM enters UPDATE at edge 3, WR_SETUP at edge 4, and `wren` first goes high after edge 5.
- A frame update is 9 cycles (UPDATE + 4×2). A bitmap load is 96 cycles.
- `pending` is 1-deep: multiple rises during one busy period give exactly one extra update.
- A rise during load is served immediately after load completes.
- Reset asserted in any state: the next cycle shows `wren`=0 and state LOAD_ADDR, and the full bitmap reload restarts from k=0.
- `IRQ_Vsync` held high continuously gives only one update; a new update requires a low then a high.

## Test plan

- Reset, ROM row r = 16'hA500+r → 32 `wren` pulses every 3 cycles at `addr` 0x00..0x1F with `ldr`=A500..A51F; `busy` falls after cycle 96.
- After load, pulse `IRQ_Vsync` with no moves → writes 0x20=32, 0x21=232, 0x22=623, 0x23=100; `wren` first high 5 cycles after the sampled rise.
- `ship_x`=1 with `move_left` → 0. `ship_x`=623 with `move_right` → 624. Left+right together → X unchanged.
- Planet at 0 on a frame → 0x22 written 624 (wrap).
- `IRQ_Vsync` rise during load and two rises during a frame update → exactly one extra update after each busy period; no `wren` high for two consecutive cycles.
- Reset asserted mid-update at w=2 → next cycle `wren`=0; bitmap reload restarts at `addr` 0x00; positions return to reset values.
